// File: rtl/ldtu_gain_select.sv
// ldtu_gain_select: picks gain_10 or gain_1 samples around gain_10 saturation.
// Both streams are delayed by PRE samples. A saturating gain_10 sample can then
// flag the PRE samples before it as well as the POST samples after it.

module ldtu_gain_select #(
    parameter int                  Nbits_12   = 12,
    parameter int                  PRE        = 5,
    parameter int                  POST_SHORT = 8,
    parameter int                  POST_LONG  = 16,
    parameter logic [Nbits_12-1:0] SAT_THR    = 12'hFFF,
    parameter int                  CNT_W      = 16
) (
    input  logic                DCLK_10,
    input  logic                reset_,
    input  logic [Nbits_12-1:0] DATA_gain_10,
    input  logic [Nbits_12-1:0] DATA_gain_01,
    input  logic                win_sel,
    output logic [Nbits_12:0]   DATA_out,
    output logic                sat_active,
    output logic [CNT_W-1:0]    sat_cnt
);

    localparam int CNT_BITS = $clog2(PRE + POST_LONG);
    localparam logic [CNT_BITS-1:0] RELOAD_SHORT = CNT_BITS'(PRE + POST_SHORT - 1);
    localparam logic [CNT_BITS-1:0] RELOAD_LONG  = CNT_BITS'(PRE + POST_LONG - 1);

    logic [Nbits_12-1:0] sr10 [PRE];
    logic [Nbits_12-1:0] sr01 [PRE];
    logic [CNT_BITS-1:0] cnt;
    logic                sat_now;
    logic                sel;
    logic [CNT_BITS-1:0] reload;

    // Saturation is judged on the undelayed sample so the window can reach back PRE samples
    always_comb begin
        sat_now = (DATA_gain_10 >= SAT_THR);
        sel     = sat_now | (cnt != '0);
        reload  = win_sel ? RELOAD_LONG : RELOAD_SHORT;
    end

    // Delay lines for both gain streams; the last tap is what reaches the output
    always_ff @(posedge DCLK_10 or negedge reset_) begin
        if (!reset_) begin
            for (int k = 0; k < PRE; k++) begin
                sr10[k] <= '0;
                sr01[k] <= '0;
            end
        end else begin
            sr10[0] <= DATA_gain_10;
            sr01[0] <= DATA_gain_01;
            for (int k = 1; k < PRE; k++) begin
                sr10[k] <= sr10[k-1];
                sr01[k] <= sr01[k-1];
            end
        end
    end

    // Window counter: reload on every saturated sample, otherwise run down to zero
    always_ff @(posedge DCLK_10 or negedge reset_) begin
        if (!reset_) begin
            cnt <= '0;
        end else if (sat_now) begin
            cnt <= reload;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Output register: gain_1 tap while the window is open, gain_10 tap otherwise
    always_ff @(posedge DCLK_10 or negedge reset_) begin
        if (!reset_) begin
            DATA_out <= '0;
        end else if (sel) begin
            DATA_out <= {1'b1, sr01[PRE-1]};
        end else begin
            DATA_out <= {1'b0, sr10[PRE-1]};
        end
    end

    // Count windows that open from idle; retriggers inside a window are not new events
    always_ff @(posedge DCLK_10 or negedge reset_) begin
        if (!reset_) begin
            sat_cnt <= '0;
        end else if (sat_now && (cnt == '0) && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

    assign sat_active = DATA_out[Nbits_12];

endmodule

// File: tb/tb_ldtu_gain_select.sv
// Directed testbench for ldtu_gain_select. Two instances share the inputs: the
// default one and one with a 4-bit event counter for checking the counter limit.

module tb_ldtu_gain_select;

    localparam int PRE = 5;

    logic        DCLK_10 = 1'b0;
    logic        reset_;
    logic [11:0] DATA_gain_10;
    logic [11:0] DATA_gain_01;
    logic        win_sel;
    logic [12:0] data_out_a;
    logic        sat_active_a;
    logic [15:0] sat_cnt_a;
    logic [12:0] data_out_b;
    logic        sat_active_b;
    logic [3:0]  sat_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    ldtu_gain_select #(.PRE(PRE)) dut_a (
        .DCLK_10      (DCLK_10),
        .reset_       (reset_),
        .DATA_gain_10 (DATA_gain_10),
        .DATA_gain_01 (DATA_gain_01),
        .win_sel      (win_sel),
        .DATA_out     (data_out_a),
        .sat_active   (sat_active_a),
        .sat_cnt      (sat_cnt_a)
    );

    ldtu_gain_select #(.PRE(PRE), .CNT_W(4)) dut_b (
        .DCLK_10      (DCLK_10),
        .reset_       (reset_),
        .DATA_gain_10 (DATA_gain_10),
        .DATA_gain_01 (DATA_gain_01),
        .win_sel      (win_sel),
        .DATA_out     (data_out_b),
        .sat_active   (sat_active_b),
        .sat_cnt      (sat_cnt_b)
    );

    // 100 MHz sample clock
    always #5 DCLK_10 = ~DCLK_10;

    // Hold reset over one edge, release on a falling edge
    task automatic do_reset();
        reset_       = 1'b0;
        DATA_gain_10 = '0;
        DATA_gain_01 = '0;
        win_sel      = 1'b0;
        @(posedge DCLK_10);
        @(negedge DCLK_10);
        reset_ = 1'b1;
    endtask

    // Present one sample pair and advance past the next rising edge
    task automatic step(input logic [11:0] g10, input logic [11:0] g01);
        DATA_gain_10 = g10;
        DATA_gain_01 = g01;
        @(posedge DCLK_10);
        #1;
    endtask

    // Asynchronous reset asserted between edges while a window is open
    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step((k == 3) ? 12'hFFF : 12'(k + 100), 12'(k));
        end
        n_checks++;
        if (data_out_a !== 13'h1002) begin
            n_fail++;
            $display("[TB] FAIL reset_pre_data: got %h expected %h", data_out_a, 13'h1002);
        end
        @(negedge DCLK_10);
        reset_ = 1'b0;
        #1;
        n_checks++;
        if (data_out_a !== 13'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h expected 0", data_out_a);
        end
        n_checks++;
        if (sat_active_a !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_sat_active: got %b expected 0", sat_active_a);
        end
        n_checks++;
        if (sat_cnt_a !== 16'd0 || sat_cnt_b !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_sat_cnt: got %0d/%0d expected 0/0", sat_cnt_a, sat_cnt_b);
        end
        @(negedge DCLK_10);
        reset_ = 1'b1;
    endtask

    // Ramp without saturation, plus a run just below threshold
    task automatic test_no_sat();
        logic [12:0] exp;
        do_reset();
        for (int k = 0; k <= 200 + PRE; k++) begin
            step((k <= 200) ? 12'(k) : 12'd0, 12'd7);
            exp = (k >= PRE) ? {1'b0, 12'(k - PRE)} : 13'h0000;
            n_checks++;
            if (data_out_a !== exp) begin
                n_fail++;
                $display("[TB] FAIL no_sat_data[%0d]: got %h expected %h", k, data_out_a, exp);
            end
        end
        for (int k = 0; k < 12; k++) begin
            step(12'hFFE, 12'd7);
            n_checks++;
            if (sat_active_a !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL below_thr_flag[%0d]: got %b expected 0", k, sat_active_a);
            end
        end
        n_checks++;
        if (sat_cnt_a !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL no_sat_cnt: got %0d expected 0", sat_cnt_a);
        end
    endtask

    // Saturation at sample 20 (and optionally s2); flagged outputs must be 15..last.
    // flip_at >= 0 toggles win_sel to 1 just before that sample.
    task automatic test_window(input string name, input logic ws, input int s2,
                               input int last, input int exp_cnt, input int flip_at);
        logic [12:0] exp;
        int          o;
        bit          flag;
        do_reset();
        win_sel = ws;
        for (int k = 0; k < 52; k++) begin
            if (k == flip_at) win_sel = 1'b1;
            step((k == 20 || k == s2) ? 12'hFFF : 12'(k + 100), 12'(k));
            if (k >= PRE) begin
                o    = k - PRE;
                flag = (o >= 15) && (o <= last);
                exp  = flag ? {1'b1, 12'(o)} : {1'b0, 12'(o + 100)};
                n_checks++;
                if (data_out_a !== exp || sat_active_a !== flag) begin
                    n_fail++;
                    $display("[TB] FAIL %s_out[%0d]: got %h/%b expected %h/%b",
                             name, o, data_out_a, sat_active_a, exp, flag);
                end
            end
        end
        n_checks++;
        if (sat_cnt_a !== 16'(exp_cnt)) begin
            n_fail++;
            $display("[TB] FAIL %s_cnt: got %0d expected %0d", name, sat_cnt_a, exp_cnt);
        end
    endtask

    // Twenty separated events: the 4-bit counter stops at 15, the 16-bit one reaches 20
    task automatic test_counter_limit();
        int exp_b;
        do_reset();
        for (int e = 0; e < 20; e++) begin
            step(12'hFFF, 12'd0);
            exp_b = (e + 1 > 15) ? 15 : e + 1;
            n_checks++;
            if (sat_cnt_b !== 4'(exp_b)) begin
                n_fail++;
                $display("[TB] FAIL cnt_limit[%0d]: got %0d expected %0d", e, sat_cnt_b, exp_b);
            end
            repeat (13) step(12'd10, 12'd0);
        end
        n_checks++;
        if (sat_cnt_a !== 16'd20) begin
            n_fail++;
            $display("[TB] FAIL cnt_wide: got %0d expected 20", sat_cnt_a);
        end
    endtask

    // Reset inside an open window, then the output restarts as unflagged zeros
    task automatic test_reset_mid_window();
        logic [12:0] exp;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step((k == 2) ? 12'hFFF : 12'(k + 100), 12'(k + 50));
        end
        n_checks++;
        if (data_out_a !== 13'h1032) begin
            n_fail++;
            $display("[TB] FAIL mid_pre_data: got %h expected %h", data_out_a, 13'h1032);
        end
        @(negedge DCLK_10);
        reset_ = 1'b0;
        #1;
        n_checks++;
        if (sat_active_a !== 1'b0 || sat_cnt_a !== 16'd0 || sat_cnt_b !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got flag %b cnt %0d/%0d expected 0 0/0",
                     sat_active_a, sat_cnt_a, sat_cnt_b);
        end
        @(negedge DCLK_10);
        reset_ = 1'b1;
        for (int k = 0; k <= PRE; k++) begin
            step(12'(k + 1), 12'd9);
            exp = (k < PRE) ? 13'h0000 : 13'h0001;
            n_checks++;
            if (data_out_a !== exp) begin
                n_fail++;
                $display("[TB] FAIL after_reset[%0d]: got %h expected %h", k, data_out_a, exp);
            end
        end
    endtask

    initial begin
        reset_       = 1'b1;
        DATA_gain_10 = '0;
        DATA_gain_01 = '0;
        win_sel      = 1'b0;
        test_reset();
        test_no_sat();
        test_window("single_short", 1'b0, -1, 27, 1, -1);
        test_window("single_long", 1'b1, -1, 35, 1, -1);
        test_window("retrigger", 1'b0, 25, 32, 1, -1);
        test_window("back_to_back", 1'b0, 33, 40, 2, -1);
        test_window("win_sel_change", 1'b0, -1, 27, 1, 23);
        test_counter_limit();
        test_reset_mid_window();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
